// File: rtl/muldiv_hilo_unit_if.sv
// Start/busy/done handshake and HI/LO result bus for muldiv_hilo_unit.
// master = the core issuing ops, slave = the multiply/divide unit.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative signed/unsigned multiply/divide unit owning the HI/LO pair (IDLE -> ITER -> FIX).
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a combinational multiplier and skip ITER.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_hilo_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   ma_r;
  logic [WIDTH-1:0]   mb_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               neg_q_r;
  logic               neg_rem_r;
  logic               zero_div_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sa_s;
  logic               sb_s;
  logic [WIDTH-1:0]   ma_s;
  logic [WIDTH-1:0]   mb_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_trial_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Operand magnitudes; op[0]=0 selects the signed variant of MULT/DIV.
  always_comb begin
    sa_s = ~bus.op[0] & bus.a[WIDTH-1];
    sb_s = ~bus.op[0] & bus.b[WIDTH-1];
    ma_s = sa_s ? neg_w(bus.a) : bus.a;
    mb_s = sb_s ? neg_w(bus.b) : bus.b;
  end

  // One iteration step: shift-add multiply or restoring divide on acc_r.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, ma_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s    = (div_trial_s >= {1'b0, mb_r});
    div_rem_s   = div_ge_s ? WIDTH'(div_trial_s - {1'b0, mb_r}) : div_trial_s[WIDTH-1:0];
    if (is_div_r) begin
      acc_next_s = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
    end else begin
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction; divide by zero returns the dividend in HI and all ones in LO.
  always_comb begin
    prod_s = neg_q_r ? neg_2w(acc_r) : acc_r;
    if (zero_div_r) begin
      fix_hi_s = neg_rem_r ? neg_w(ma_r) : ma_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else if (is_div_r) begin
      fix_hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered handshake and HI/LO outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      acc_r      <= {(2*WIDTH){1'b0}};
      ma_r       <= {WIDTH{1'b0}};
      mb_r       <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      zero_div_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dbz_r      <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                ma_r       <= ma_s;
                mb_r       <= mb_s;
                cnt_r      <= {CW{1'b0}};
                is_div_r   <= 1'b0;
                neg_q_r    <= sa_s ^ sb_s;
                neg_rem_r  <= sa_s ^ sb_s;
                zero_div_r <= 1'b0;
                dbz_r      <= 1'b0;
                busy_r     <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                acc_r      <= {{WIDTH{1'b0}}, ma_s} * {{WIDTH{1'b0}}, mb_s};
                state_r    <= FIX;
`else
                acc_r      <= {{WIDTH{1'b0}}, mb_s};
                state_r    <= ITER;
`endif
              end
              OP_DIV, OP_DIVU: begin
                ma_r       <= ma_s;
                mb_r       <= mb_s;
                acc_r      <= {{WIDTH{1'b0}}, ma_s};
                cnt_r      <= {CW{1'b0}};
                is_div_r   <= 1'b1;
                neg_q_r    <= sa_s ^ sb_s;
                neg_rem_r  <= sa_s;
                zero_div_r <= (bus.b == {WIDTH{1'b0}});
                dbz_r      <= 1'b0;
                busy_r     <= 1'b1;
                state_r    <= ITER;
              end
              OP_MTHI: hi_r <= bus.a;
              OP_MTLO: lo_r <= bus.a;
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIX;
          end else begin
            state_r <= ITER;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          dbz_r   <= zero_div_r;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit (WIDTH=32).
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_hilo_unit;
  localparam int W = 32;
  localparam int DIV_LAT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   edges;
  int   busy_cycles;
  int   done_seen;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge: drives start for one edge, returns #1 after the start edge.
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done (bounded) and busy-high samples along the way.
  task automatic wait_done();
    edges       = 0;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && edges < 200) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edbz);
    launch(op, a, b);
    wait_done();
    chk({tag, "_latency"}, 64'(edges), 64'(lat));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(1'b0));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_hi", 64'(bus.hi), 64'h0);
    chk("reset_lo", 64'(bus.lo), 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'h0);

    launch(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done();
    chk("multu_latency", 64'(edges), 64'(MUL_LAT));
    chk("multu_busy_cycles", 64'(busy_cycles), 64'(MUL_LAT));
    chk("multu_hi", 64'(bus.hi), 64'h1);
    chk("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(bus.done), 64'h0);

    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'h0000_0005, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negneg", 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, DIV_LAT, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    run_op("div_posneg", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", 3'b011, 32'h0000_0007, 32'h0000_0002, DIV_LAT, 32'h1, 32'h3, 1'b0);
    run_op("div_zero", 3'b010, 32'h0000_1234, 32'h0, DIV_LAT, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk);
    #1;
    chk("dbz_sticky", 64'(bus.div_by_zero), 64'h1);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 1'b0);
    run_op("mult_big", 3'b001, 32'h8000_0001, 32'h8000_0001, MUL_LAT, 32'h4000_0001, 32'h0000_0001, 1'b0);

    // Start while busy is ignored; operand changes mid-operation have no effect.
    launch(3'b011, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    chk("ignore_latency", 64'(edges), 64'(DIV_LAT - 5));
    chk("ignore_lo", 64'(bus.lo), 64'd14);
    chk("ignore_hi", 64'(bus.hi), 64'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_no_queue_busy", 64'(bus.busy), 64'h0);
    chk("ignore_hold_lo", 64'(bus.lo), 64'd14);

    // Reset in the middle of a divide.
    launch(3'b011, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_hi", 64'(bus.hi), 64'h0);
    chk("midreset_lo", 64'(bus.lo), 64'h0);
    chk("midreset_busy", 64'(bus.busy), 64'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_seen++;
      @(posedge clk);
      #1;
    end
    chk("midreset_no_done", 64'(done_seen), 64'h0);

    // MTHI then MTLO on back-to-back cycles.
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("mthi_busy", 64'(bus.busy), 64'h0);
    bus.op = 3'b101;
    bus.a  = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("mtlo_lo", 64'(bus.lo), 64'h1234_5678);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("mtlo_busy", 64'(bus.busy), 64'h0);
    chk("mtlo_done", 64'(bus.done), 64'h0);
    bus.op = 3'b110;
    bus.a  = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("op110_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("op110_lo", 64'(bus.lo), 64'h1234_5678);
    chk("op110_busy", 64'(bus.busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
